// File: rtl/io_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// io_reg_bank_pkg
// Shared memory-map definitions for the I/O register bus plus the per-bit CPU
// write helper used by every register slice.
//   - IOREG_ADDR_* : bus addresses of the standard peripheral registers
//   - IOREG_MASK_* : convenience masks for RW_MASK / W1C_MASK parameters
//   - ioreg_cpu_write() : value a register takes after a CPU write
// -----------------------------------------------------------------------------
package io_reg_bank_pkg;

    // Bus register addresses (serial data/control, interrupt flag/enable)
    localparam logic [15:0] IOREG_ADDR_SB = 16'hFF01;
    localparam logic [15:0] IOREG_ADDR_SC = 16'hFF02;
    localparam logic [15:0] IOREG_ADDR_IF = 16'hFF0F;
    localparam logic [15:0] IOREG_ADDR_IE = 16'hFFFF;

    // Access-mask shorthands
    localparam logic [7:0] IOREG_MASK_ALL  = 8'hFF;
    localparam logic [7:0] IOREG_MASK_NONE = 8'h00;

    // CPU write effect: RW bits load the bus value, W1C bits clear where the
    // bus carries a 1, all remaining (read-only) bits keep their value.
    function automatic logic [7:0] ioreg_cpu_write(
        input logic [7:0] cur,
        input logic [7:0] wdata,
        input logic [7:0] rw_mask,
        input logic [7:0] w1c_mask
    );
        logic [7:0] ro_mask;
        ro_mask = ~(rw_mask | w1c_mask);
        return (wdata & rw_mask)
             | (cur & ~wdata & w1c_mask)
             | (cur & ro_mask);
    endfunction

endpackage

// File: rtl/io_reg_bit_slice.sv
// -----------------------------------------------------------------------------
// io_reg_bit_slice
// One 8-bit I/O register with per-bit access masks and hardware set/load.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   cpu_we            : CPU write hit on this register this cycle
//   wr_data           : CPU write data (bus value)
//   hw_set            : per-bit level set, ORed in unless hw_load is active
//   hw_load, hw_data  : whole-register hardware load (beats a CPU write)
//   q                 : current register contents
// -----------------------------------------------------------------------------
module io_reg_bit_slice
    import io_reg_bank_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] RW_MASK   = 8'hFF,
    parameter logic [7:0] W1C_MASK  = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_we,
    input  logic [7:0] wr_data,
    input  logic [7:0] hw_set,
    input  logic       hw_load,
    input  logic [7:0] hw_data,
    output logic [7:0] q
);

    logic [7:0] q_r;
    logic [7:0] next_s;

    // Next-state priority: hw_load, then CPU write, then hold; hw_set is ORed
    // last so a set racing a W1C clear still leaves the bit set.
    always_comb begin
        next_s = q_r;
        if (hw_load) begin
            next_s = hw_data;
        end else if (cpu_we) begin
            next_s = ioreg_cpu_write(q_r, wr_data, RW_MASK, W1C_MASK) | hw_set;
        end else begin
            next_s = q_r | hw_set;
        end
    end

    // Register storage
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/io_reg_bank.sv
// -----------------------------------------------------------------------------
// io_reg_bank
// Bank of NUM_REGS contiguous 8-bit I/O registers starting at BASE_ADDR.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   bus_addr            : I/O bus address
//   bus_data (inout)    : driven with the selected register on a read only
//   bus_we_l, bus_re_l  : active-low write / read enables
//   hw_set, hw_load, hw_data : hardware set / load per register
//   reg_q               : packed register contents, register i at [8i+7:8i]
//   wr_strobe           : registered one-cycle pulse after a CPU write hit
// -----------------------------------------------------------------------------
module io_reg_bank
    import io_reg_bank_pkg::*;
#(
    parameter int                        NUM_REGS  = 2,
    parameter logic [15:0]               BASE_ADDR = 16'hFF01,
    parameter logic [8*NUM_REGS-1:0]     RESET_VAL = {NUM_REGS{8'h00}},
    parameter logic [8*NUM_REGS-1:0]     RW_MASK   = {NUM_REGS{8'hFF}},
    parameter logic [8*NUM_REGS-1:0]     W1C_MASK  = {NUM_REGS{8'h00}}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [15:0]              bus_addr,
    inout  wire  [7:0]               bus_data,
    input  logic                     bus_we_l,
    input  logic                     bus_re_l,
    input  logic [8*NUM_REGS-1:0]    hw_set,
    input  logic [NUM_REGS-1:0]      hw_load,
    input  logic [8*NUM_REGS-1:0]    hw_data,
    output logic [8*NUM_REGS-1:0]    reg_q,
    output logic [NUM_REGS-1:0]      wr_strobe
);

    // Parameter sanity, caught at elaboration
    if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
        $error("io_reg_bank: NUM_REGS must be in 1..16");
    end
    if ((32'(BASE_ADDR) + 32'(NUM_REGS) - 32'd1) > 32'h0000_FFFF) begin : g_bad_wrap
        $error("io_reg_bank: register range wraps past 16'hFFFF");
    end
    if ((RW_MASK & W1C_MASK) != {NUM_REGS{8'h00}}) begin : g_bad_mask
        $error("io_reg_bank: RW_MASK and W1C_MASK overlap");
    end

    logic [NUM_REGS-1:0] hit_s;
    logic [7:0]          rd_data_s;
    logic                rd_drive_s;
    logic [7:0]          slice_q_s [NUM_REGS];

    // Address decode and read mux; at most one register can hit
    always_comb begin
        hit_s     = {NUM_REGS{1'b0}};
        rd_data_s = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus_addr == (BASE_ADDR + 16'(i))) begin
                hit_s[i]  = 1'b1;
                rd_data_s = slice_q_s[i];
            end else begin
                hit_s[i]  = 1'b0;
            end
        end
    end

    // A concurrent write suppresses the read drive so the bus value is the
    // master's write data, never contention with our own output.
    assign rd_drive_s = ~bus_re_l & bus_we_l & (|hit_s);
    assign bus_data   = rd_drive_s ? rd_data_s : 8'hzz;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        io_reg_bit_slice #(
            .RESET_VAL (RESET_VAL[8*g +: 8]),
            .RW_MASK   (RW_MASK[8*g +: 8]),
            .W1C_MASK  (W1C_MASK[8*g +: 8])
        ) u_slice (
            .clock   (clock),
            .reset   (reset),
            .cpu_we  (hit_s[g] & ~bus_we_l),
            .wr_data (bus_data),
            .hw_set  (hw_set[8*g +: 8]),
            .hw_load (hw_load[g]),
            .hw_data (hw_data[8*g +: 8]),
            .q       (slice_q_s[g])
        );
    end

    // Pack slice outputs onto the flat register bus
    always_comb begin
        reg_q = {(8*NUM_REGS){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[8*i +: 8] = slice_q_s[i];
        end
    end

    // Write strobes: one pulse per write cycle, suppressed by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_strobe <= {NUM_REGS{1'b0}};
        end else if (!bus_we_l) begin
            wr_strobe <= hit_s;
        end else begin
            wr_strobe <= {NUM_REGS{1'b0}};
        end
    end

endmodule
